// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divider sequencer for DIV/DIVU.
// Takes an operand pair from Execute, holds busy for the hazard unit, then pulses done with HI/LO results.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    FIX,
    DONE
  } stateT;

  stateT state, stateNext;

  logic [WIDTH-1:0] opA, opB;
  logic             isSigned;
  logic [WIDTH-1:0] absB;
  logic [WIDTH-1:0] quo, rem;
  logic             qSign, rSign;
  logic [CW-1:0]    counter;

  logic             aNeg, bNeg;
  logic [WIDTH-1:0] absAComb, absBComb;
  logic [WIDTH:0]   remShift;
  logic [WIDTH-1:0] remDiff;
  logic             remGe;

  // Magnitudes and the trial subtraction of one restoring step.
  always_comb begin
    aNeg     = isSigned & opA[WIDTH-1];
    bNeg     = isSigned & opB[WIDTH-1];
    absAComb = aNeg ? -opA : opA;
    absBComb = bNeg ? -opB : opB;
    remShift = {rem, quo[WIDTH-1]};
    remGe    = (remShift >= {1'b0, absB});
    remDiff  = remShift[WIDTH-1:0] - absB;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (start_i && !cancel_i) stateNext = PREP;
      end
      PREP: begin
        if (cancel_i)            stateNext = IDLE;
        else if (opB == '0)      stateNext = DONE;
        else                     stateNext = RUN;
      end
      RUN: begin
        if (cancel_i)                 stateNext = IDLE;
        else if (counter == CW'(1))   stateNext = FIX;
      end
      FIX: begin
        if (cancel_i) stateNext = IDLE;
        else          stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Status flags are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      busy_o <= (stateNext == PREP) || (stateNext == RUN) || (stateNext == FIX);
      done_o <= (stateNext == DONE);
    end
  end

  // Result registers are only written on a transition into DONE, so a cancel leaves them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      opA      <= '0;
      opB      <= '0;
      isSigned <= 1'b0;
      absB     <= '0;
      quo      <= '0;
      rem      <= '0;
      qSign    <= 1'b0;
      rSign    <= 1'b0;
      counter  <= '0;
      hi_o     <= '0;
      lo_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (stateNext == PREP) begin
            opA      <= opa_i;
            opB      <= opb_i;
            isSigned <= signed_i;
          end
        end
        PREP: begin
          absB    <= absBComb;
          qSign   <= aNeg ^ bNeg;
          rSign   <= aNeg;
          rem     <= '0;
          quo     <= absAComb;
          counter <= CW'(WIDTH);
          if (stateNext == DONE) begin
            lo_o <= '1;
            hi_o <= opA;
          end
        end
        RUN: begin
          rem     <= remGe ? remDiff : remShift[WIDTH-1:0];
          quo     <= {quo[WIDTH-2:0], remGe};
          counter <= counter - CW'(1);
        end
        FIX: begin
          if (stateNext == DONE) begin
            lo_o <= qSign ? -quo : quo;
            hi_o <= rSign ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: a scoreboard queue holds expected HI/LO per started divide,
// popped when done_o pulses; busy/done timing is checked cycle by cycle.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opa_i;
  logic [31:0] opb_i;
  logic        cancel_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [63:0] scoreboard[$];
  logic [31:0] lastHi, lastLo;

  div_ctrl #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .signed_i (signed_i),
    .opa_i    (opa_i),
    .opb_i    (opb_i),
    .cancel_i (cancel_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference results from the language's own division operators.
  function automatic logic [63:0] modelDiv(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sg) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, observed, expected);
    end
  endtask

  // Drives a one-cycle start; returns at the negedge of cycle 1.
  task automatic issueStart(input logic sg, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start_i  = 1'b1;
    cancel_i = 1'b0;
    signed_i = sg;
    opa_i    = a;
    opb_i    = b;
    cyc      = 0;
    @(negedge clk);
    start_i  = 1'b0;
    cyc      = 1;
  endtask

  task automatic applyStimulus(input logic sg, input logic [31:0] a, input logic [31:0] b, input bit noise);
    int          expDone, expBusyLast;
    bit          gotDone;
    logic [63:0] exp;
    expDone     = (b == 32'd0) ? 2 : 35;
    expBusyLast = (b == 32'd0) ? 1 : 34;
    scoreboard.push_back(modelDiv(sg, a, b));
    gotDone = 1'b0;
    issueStart(sg, a, b);
    for (int k = 1; k <= expDone + 1; k++) begin
      cyc = k;
      checkOutput("busy", 64'(busy_o), 64'(k <= expBusyLast));
      checkOutput("done", 64'(done_o), 64'(k == expDone));
      if (done_o === 1'b1) begin
        gotDone = 1'b1;
        checkOutput("sbNotEmpty", 64'(scoreboard.size() > 0), 64'd1);
        if (scoreboard.size() > 0) begin
          exp = scoreboard.pop_front();
          checkOutput("hi", 64'(hi_o), 64'(exp[63:32]));
          checkOutput("lo", 64'(lo_o), 64'(exp[31:0]));
          lastHi = exp[63:32];
          lastLo = exp[31:0];
        end
      end
      if (noise && k >= 3 && k <= expDone) begin
        opa_i    = $urandom;
        opb_i    = $urandom;
        signed_i = ~signed_i;
        start_i  = (k == expDone) ? 1'b1 : k[0];
      end else begin
        start_i = 1'b0;
      end
      if (k <= expDone) @(negedge clk);
    end
    checkOutput("gotDone", 64'(gotDone), 64'd1);
  endtask

  initial begin
    bit sawDone;
    rst      = 1'b1;
    start_i  = 1'b0;
    signed_i = 1'b0;
    opa_i    = '0;
    opb_i    = '0;
    cancel_i = 1'b0;
    lastHi   = '0;
    lastLo   = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", 64'(busy_o), 64'd0);
    checkOutput("rstDone", 64'(done_o), 64'd0);
    checkOutput("rstHi", 64'(hi_o), 64'd0);
    checkOutput("rstLo", 64'(lo_o), 64'd0);
    rst = 1'b0;

    applyStimulus(1'b0, 32'd100, 32'd7, 1'b0);
    checkOutput("hold100by7", {hi_o, lo_o}, {32'd2, 32'd14});
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    applyStimulus(1'b0, 32'd5, 32'd0, 1'b0);
    applyStimulus(1'b1, 32'hFFFF_FFFD, 32'd0, 1'b0);

    // Cancel mid-run after a completed 100/7.
    applyStimulus(1'b0, 32'd100, 32'd7, 1'b0);
    issueStart(1'b0, 32'd50, 32'd3);
    repeat (9) @(negedge clk);
    cyc      = 10;
    cancel_i = 1'b1;
    @(negedge clk);
    cyc      = 11;
    checkOutput("cancelBusy", 64'(busy_o), 64'd0);
    checkOutput("cancelDone", 64'(done_o), 64'd0);
    checkOutput("cancelHi", 64'(hi_o), 64'd2);
    checkOutput("cancelLo", 64'(lo_o), 64'd14);
    cancel_i = 1'b0;
    applyStimulus(1'b0, 32'd50, 32'd3, 1'b0);

    // Divide-by-zero cancelled in PREP writes nothing.
    issueStart(1'b0, 32'd9, 32'd0);
    cancel_i = 1'b1;
    @(negedge clk);
    cyc      = 2;
    cancel_i = 1'b0;
    checkOutput("cancelPrepBusy", 64'(busy_o), 64'd0);
    checkOutput("cancelPrepDone", 64'(done_o), 64'd0);
    checkOutput("cancelPrepRes", {hi_o, lo_o}, {lastHi, lastLo});

    // Cancel and start together in IDLE: nothing starts.
    @(negedge clk);
    start_i  = 1'b1;
    cancel_i = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
    cancel_i = 1'b0;
    cyc      = 1;
    checkOutput("cancelStartBusy", 64'(busy_o), 64'd0);
    @(negedge clk);
    cyc      = 2;
    checkOutput("cancelStartDone", 64'(done_o), 64'd0);

    // Operand noise and start pulses while busy are ignored.
    applyStimulus(1'b1, 32'hFFFF_FC18, 32'd7, 1'b1);
    applyStimulus(1'b0, 32'hDEAD_BEEF, 32'h0001_2345, 1'b1);

    // Reset in the middle of a divide.
    issueStart(1'b1, 32'hFFFF_FC18, 32'd7);
    repeat (19) @(negedge clk);
    cyc = 20;
    rst = 1'b1;
    @(negedge clk);
    cyc = 21;
    checkOutput("midRstBusy", 64'(busy_o), 64'd0);
    checkOutput("midRstDone", 64'(done_o), 64'd0);
    checkOutput("midRstHi", 64'(hi_o), 64'd0);
    checkOutput("midRstLo", 64'(lo_o), 64'd0);
    rst     = 1'b0;
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o === 1'b1) sawDone = 1'b1;
    end
    checkOutput("noDoneAfterRst", 64'(sawDone), 64'd0);
    applyStimulus(1'b1, 32'hFFFF_FC18, 32'd7, 1'b0);

    checkOutput("sbDrained", 64'(scoreboard.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
